// File: rtl/hex_display_scanner.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// Latches a 128-bit block and shows one 32-bit page of it, one nibble per digit slot.
module hex_display_scanner #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter int unsigned BLANK_CYCLES  = 16,
    parameter int unsigned AUTO_PAGE_DIV = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_valid,
    input  logic [127:0] data_in,
    input  logic         page_next,
    output logic [3:0]   nibble_out,
    output logic [7:0]   an_out,
    output logic         dp_out,
    output logic [1:0]   page_out
);

    localparam int unsigned SlotW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned AutoW = (AUTO_PAGE_DIV > 1) ? $clog2(AUTO_PAGE_DIV) : 1;
    localparam logic [SlotW-1:0] SlotLast  = SlotW'(REFRESH_DIV - 1);
    localparam logic [SlotW-1:0] SlotBlank = SlotW'(BLANK_CYCLES);
    localparam logic [AutoW-1:0] AutoLast  = AutoW'(AUTO_PAGE_DIV - 1);

    logic [127:0]     data_q, data_d;
    logic             loaded_q, loaded_d;
    logic [1:0]       page_q, page_d;
    logic [2:0]       digit_q, digit_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [AutoW-1:0] auto_q, auto_d;
    logic             auto_tick;

    logic [31:0]      word;
    logic             lit;
    logic [3:0]       nibble_d;
    logic [7:0]       an_d;
    logic             dp_d;

    always_comb begin
        slot_d    = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
        digit_d   = (slot_q == SlotLast) ? digit_q + 3'd1 : digit_q;
        auto_d    = auto_q;
        auto_tick = 1'b0;
        data_d    = data_q;
        loaded_d  = loaded_q;
        page_d    = page_q;

        // The auto-page timer only runs once something is on display.
        if (AUTO_PAGE_DIV != 0 && loaded_q) begin
            if (auto_q == AutoLast) begin
                auto_d    = '0;
                auto_tick = 1'b1;
            end else begin
                auto_d = auto_q + 1'b1;
            end
        end

        if (load_valid) begin
            data_d   = data_in;
            loaded_d = 1'b1;
            page_d   = 2'd0;
            auto_d   = '0;
        end else if (loaded_q && (page_next || auto_tick)) begin
            page_d = page_q + 2'd1;
        end
    end

    always_comb begin
        unique case (page_q)
            2'd0:    word = data_q[127:96];
            2'd1:    word = data_q[95:64];
            2'd2:    word = data_q[63:32];
            default: word = data_q[31:0];
        endcase
        lit      = loaded_q && (slot_q >= SlotBlank);
        nibble_d = loaded_q ? word[{digit_q, 2'b00} +: 4] : 4'h0;
        an_d     = lit ? ~(8'h01 << digit_q) : 8'hFF;
        dp_d     = ~(lit && (digit_q == {1'b0, page_q}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            loaded_q   <= 1'b0;
            page_q     <= 2'd0;
            digit_q    <= 3'd0;
            slot_q     <= '0;
            auto_q     <= '0;
            nibble_out <= 4'h0;
            an_out     <= 8'hFF;
            dp_out     <= 1'b1;
            page_out   <= 2'd0;
        end else begin
            data_q     <= data_d;
            loaded_q   <= loaded_d;
            page_q     <= page_d;
            digit_q    <= digit_d;
            slot_q     <= slot_d;
            auto_q     <= auto_d;
            nibble_out <= nibble_d;
            an_out     <= an_d;
            dp_out     <= dp_d;
            page_out   <= page_q;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: a manual-page instance and an auto-page instance share stimulus
// and are compared every cycle against a cycle-count based reference model.
module tb_hex_display_scanner;

    localparam int unsigned R = 4;
    localparam int unsigned B = 1;
    localparam int unsigned A = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         load_valid;
    logic         page_next;
    logic [127:0] data_in;
    logic [3:0]   nib0, nib1;
    logic [7:0]   an0, an1;
    logic         dp0, dp1;
    logic [1:0]   pg0, pg1;

    hex_display_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .AUTO_PAGE_DIV(0)) dut_manual (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .data_in(data_in),
        .page_next(page_next), .nibble_out(nib0), .an_out(an0), .dp_out(dp0), .page_out(pg0)
    );

    hex_display_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B), .AUTO_PAGE_DIV(A)) dut_auto (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .data_in(data_in),
        .page_next(page_next), .nibble_out(nib1), .an_out(an1), .dp_out(dp1), .page_out(pg1)
    );

    always #5 clk = ~clk;

    int checks;
    int errors;

    // Reference model: time is the count of edges since reset release.
    int           n;
    bit           m_loaded;
    logic [127:0] m_data;
    int           m_page[2];
    int           m_since;
    logic [7:0]   e_an[2];
    logic [3:0]   e_nib[2];
    logic         e_dp[2];
    logic [1:0]   e_page[2];
    logic [31:0]  page_word[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        n        = 0;
        m_loaded = 1'b0;
        m_data   = '0;
        m_since  = 0;
        for (int c = 0; c < 2; c++) begin
            m_page[c] = 0;
            e_an[c]   = 8'hFF;
            e_nib[c]  = 4'h0;
            e_dp[c]   = 1'b1;
            e_page[c] = 2'd0;
        end
    endtask

    task automatic model_edge();
        int  slot;
        int  digit;
        bit  lit;
        bit  tick;
        slot  = n % R;
        digit = (n / R) % 8;
        lit   = m_loaded && (slot >= B);
        for (int c = 0; c < 2; c++) begin
            e_an[c]   = lit ? ~(8'h01 << digit) : 8'hFF;
            e_nib[c]  = m_loaded ? 4'((m_data >> (96 - 32 * m_page[c] + 4 * digit)) & 128'hF)
                                 : 4'h0;
            e_dp[c]   = !(lit && digit == m_page[c]);
            e_page[c] = 2'(m_page[c]);
        end
        n++;
        if (load_valid) begin
            m_data   = data_in;
            m_loaded = 1'b1;
            m_since  = 0;
            m_page[0] = 0;
            m_page[1] = 0;
        end else if (m_loaded) begin
            m_since++;
            tick = (m_since % A) == 0;
            if (page_next) m_page[0] = (m_page[0] + 1) % 4;
            if (page_next || tick) m_page[1] = (m_page[1] + 1) % 4;
        end
    endtask

    // One clock: model follows the edge, outputs are compared on the falling edge,
    // then single-cycle strobes are dropped.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_eq("an_manual", 32'(an0), 32'(e_an[0]));
        check_eq("nibble_manual", 32'(nib0), 32'(e_nib[0]));
        check_eq("dp_manual", 32'(dp0), 32'(e_dp[0]));
        check_eq("page_manual", 32'(pg0), 32'(e_page[0]));
        check_eq("an_auto", 32'(an1), 32'(e_an[1]));
        check_eq("nibble_auto", 32'(nib1), 32'(e_nib[1]));
        check_eq("dp_auto", 32'(dp1), 32'(e_dp[1]));
        check_eq("page_auto", 32'(pg1), 32'(e_page[1]));
        load_valid = 1'b0;
        page_next  = 1'b0;
    endtask

    // One full scan period on the manual instance: per-digit nibble, lit time and dp.
    task automatic scan_collect(input logic [31:0] word, input int pg);
        int seen[8];
        int low_cnt[8];
        int dp_cnt[8];
        for (int d = 0; d < 8; d++) begin
            seen[d] = -1;
            low_cnt[d] = 0;
            dp_cnt[d] = 0;
        end
        for (int t = 0; t < 8 * R; t++) begin
            step();
            for (int d = 0; d < 8; d++) begin
                if (an0[d] == 1'b0) begin
                    seen[d] = int'(nib0);
                    low_cnt[d]++;
                    if (dp0 == 1'b0) dp_cnt[d]++;
                end
            end
        end
        for (int d = 0; d < 8; d++) begin
            check_eq($sformatf("scan_p%0d_nib_d%0d", pg, d), 32'(seen[d]), 32'(word[4 * d +: 4]));
            check_eq($sformatf("scan_p%0d_low_d%0d", pg, d), 32'(low_cnt[d]), 32'(R - B));
            check_eq($sformatf("scan_p%0d_dp_d%0d", pg, d), 32'(dp_cnt[d]),
                     (d == pg) ? 32'(R - B) : 32'd0);
        end
    endtask

    logic [127:0] blk;
    int           guard;

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        load_valid   = 1'b0;
        page_next    = 1'b0;
        data_in      = '0;
        page_word[0] = 32'h00112233;
        page_word[1] = 32'h44556677;
        page_word[2] = 32'h8899AABB;
        page_word[3] = 32'hCCDDEEFF;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_an", 32'(an0), 32'hFF);
        check_eq("rst_nibble", 32'(nib0), 32'h0);
        check_eq("rst_dp", 32'(dp0), 32'h1);
        check_eq("rst_page", 32'(pg1), 32'h0);
        rst_n = 1'b1;

        // Dark display without a load
        repeat (100) step();
        check_eq("noload_an", 32'(an0), 32'hFF);

        // Load and scan page 0
        data_in    = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        load_valid = 1'b1;
        step();
        step();
        scan_collect(page_word[0], 0);
        check_eq("load_page", 32'(pg0), 32'h0);

        // Manual page advance through all pages and back to 0
        for (int p = 1; p < 4; p++) begin
            page_next = 1'b1;
            step();
            step();
            check_eq($sformatf("adv_page%0d", p), 32'(pg0), 32'(p));
            scan_collect(page_word[p], p);
        end
        page_next = 1'b1;
        step();
        step();
        check_eq("adv_wrap", 32'(pg0), 32'h0);

        // Load wins over a simultaneous page_next
        repeat (2) begin
            page_next = 1'b1;
            step();
        end
        step();
        check_eq("pre_load_page", 32'(pg0), 32'h2);
        blk        = {$urandom, $urandom, $urandom, $urandom};
        data_in    = blk;
        load_valid = 1'b1;
        page_next  = 1'b1;
        step();
        step();
        check_eq("load_over_next", 32'(pg0), 32'h0);
        scan_collect(blk[127:96], 0);

        // Random loads and page pulses
        for (int t = 0; t < 300; t++) begin
            page_next  = ($urandom % 8) == 0;
            load_valid = ($urandom % 40) == 0;
            data_in    = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        // Auto page advance, with one page_next landing on an auto tick
        data_in    = {$urandom, $urandom, $urandom, $urandom};
        load_valid = 1'b1;
        step();
        for (int s = 1; s <= 260; s++) begin
            if (s == 128) page_next = 1'b1;
            step();
            if (s % 64 == 0) check_eq($sformatf("auto_s%0d", s), 32'(pg1), 32'((s / 64 - 1) % 4));
            if (s % 64 == 1 && s > 1) check_eq($sformatf("auto_s%0d", s), 32'(pg1),
                                               32'((s / 64) % 4));
        end

        // Asynchronous reset in the middle of a lit slot
        guard = 0;
        while (an0 == 8'hFF && guard < 8) begin
            step();
            guard++;
        end
        check_eq("pre_reset_lit", 32'(an0 != 8'hFF), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_an_manual", 32'(an0), 32'hFF);
        check_eq("async_an_auto", 32'(an1), 32'hFF);
        check_eq("async_nibble", 32'(nib0), 32'h0);
        check_eq("async_dp", 32'(dp0), 32'h1);
        check_eq("async_page", 32'(pg1), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) step();
        check_eq("post_reset_dark", 32'(an0), 32'hFF);
        blk        = {$urandom, $urandom, $urandom, $urandom};
        data_in    = blk;
        load_valid = 1'b1;
        step();
        step();
        scan_collect(blk[127:96], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
